// File: rtl/n64_tas_pkg.sv
// Shared definitions for the N64 TAS input path.
// Contents:
//   FRAME_W       - width of one controller frame
//   NEUTRAL_FRAME - frame with no buttons pressed and the stick centred
//   frame_t       - one controller frame
//   rd_state_t    - states of the frame FIFO read port
package n64_tas_pkg;

  localparam int FRAME_W = 32;

  typedef logic [FRAME_W-1:0] frame_t;

  localparam frame_t NEUTRAL_FRAME = 32'h0000_0000;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_FETCH = 1'b1
  } rd_state_t;

endpackage

// File: rtl/sync_ram_1r1w.sv
// Simple dual-port RAM: one write port and one read port with a registered
// read. There is no read-during-write bypass. A read of the address being
// written in the same cycle returns the old contents.
// Ports:
//   clk     - clock
//   i_we    - write enable
//   i_waddr - write address
//   i_wdata - write data
//   i_re    - read enable; o_rdata updates on the next edge
//   i_raddr - read address
//   o_rdata - registered read data; holds between reads
module sync_ram_1r1w #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_q;

  // The storage has no reset, so that it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_q <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/n64_frame_fifo.sv
// Per-console controller-frame buffer. The serial handler writes frames into
// this buffer. The protocol engine polls it and receives one frame per poll.
// A poll that finds the buffer empty replays the last frame returned (the
// hold register) and counts an underrun.
// Ports:
//   clk, rst       - clock; synchronous active-high reset
//   wr_en, wr_data - write strobe and frame from the serial handler
//   request_frame  - high while one more write will be accepted
//   poll           - request for the next frame from the protocol engine
//   frame_data     - frame returned for the latest poll
//   frame_valid    - one-cycle pulse one cycle after an accepted poll
//   underrun       - pulse with frame_valid when the poll found the buffer empty
//   overrun        - pulse one cycle after a write that was dropped because the buffer was full
//   level          - number of frames currently stored
//   underrun_count - saturating number of underruns since reset
module n64_frame_fifo
  import n64_tas_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int REQ_HOLDOFF = 4,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [FRAME_W-1:0]       wr_data,
  output logic                     request_frame,
  input  logic                     poll,
  output logic [FRAME_W-1:0]       frame_data,
  output logic                     frame_valid,
  output logic                     underrun,
  output logic                     overrun,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         underrun_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int HO_W  = (REQ_HOLDOFF > 0) ? $clog2(REQ_HOLDOFF + 1) : 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [HO_W-1:0]  HO_LOAD  = HO_W'(REQ_HOLDOFF);

  rd_state_t          r_state, w_state_next;
  logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]   r_level, w_level_next;
  logic [HO_W-1:0]    r_holdoff, w_holdoff_next;
  logic               r_req;
  logic               r_overrun;
  logic               r_fetch_under;
  frame_t             r_hold;
  logic [CNT_W-1:0]   r_under_cnt;
  frame_t             w_ram_q;

  logic w_full, w_empty;
  logic w_poll_ok, w_in_fetch;
  logic w_wr_ok, w_rd_ok, w_poll_under;

  // Full and empty use the level at the start of the cycle. A write into an
  // empty buffer cannot satisfy a poll in the same cycle.
  assign w_full       = (r_level == LVL_FULL);
  assign w_empty      = (r_level == '0);
  assign w_wr_ok      = wr_en && !w_full;
  assign w_rd_ok      = w_poll_ok && !w_empty;
  assign w_poll_under = w_poll_ok && w_empty;

  // Read-port FSM. A poll that arrives while a fetch is in flight is ignored.
  always_comb begin
    w_state_next = r_state;
    w_poll_ok    = 1'b0;
    w_in_fetch   = 1'b0;
    case (r_state)
      RD_IDLE: begin
        if (poll) begin
          w_poll_ok    = 1'b1;
          w_state_next = RD_FETCH;
        end
      end
      RD_FETCH: begin
        w_in_fetch   = 1'b1;
        w_state_next = RD_IDLE;
      end
      default: w_state_next = RD_IDLE;
    endcase
  end

  always_comb begin
    w_level_next = r_level;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_level_next = r_level + LVL_W'(1);
      2'b01:   w_level_next = r_level - LVL_W'(1);
      default: w_level_next = r_level;
    endcase
  end

  // A dropped write does not reload the holdoff. Only frames that were stored
  // throttle the serial handler.
  always_comb begin
    w_holdoff_next = r_holdoff;
    if (w_wr_ok) begin
      w_holdoff_next = HO_LOAD;
    end else if (r_holdoff != '0) begin
      w_holdoff_next = r_holdoff - HO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RD_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_holdoff     <= '0;
      r_req         <= 1'b0;
      r_overrun     <= 1'b0;
      r_fetch_under <= 1'b0;
      r_hold        <= NEUTRAL_FRAME;
      r_under_cnt   <= '0;
    end else begin
      r_state       <= w_state_next;
      r_level       <= w_level_next;
      r_holdoff     <= w_holdoff_next;
      r_req         <= (w_level_next != LVL_FULL) && (w_holdoff_next == '0);
      r_overrun     <= wr_en && w_full;
      r_fetch_under <= w_poll_under;
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      // Capture the fetched frame so that later underruns can replay it.
      if (w_in_fetch && !r_fetch_under) begin
        r_hold <= w_ram_q;
      end
      if (w_poll_under && (r_under_cnt != '1)) begin
        r_under_cnt <= r_under_cnt + CNT_W'(1);
      end
    end
  end

  sync_ram_1r1w #(
    .DEPTH (DEPTH),
    .WIDTH (FRAME_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_ok),
    .i_waddr (r_wr_ptr),
    .i_wdata (wr_data),
    .i_re    (w_rd_ok),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_q)
  );

  // In the fetch cycle the fresh RAM word is presented directly. Otherwise the
  // output shows the hold register. A reset during the fetch cycle suppresses
  // the pending result.
  assign frame_valid    = w_in_fetch && !rst;
  assign underrun       = w_in_fetch && r_fetch_under && !rst;
  assign frame_data     = (w_in_fetch && !r_fetch_under && !rst) ? w_ram_q : r_hold;
  assign request_frame  = r_req;
  assign overrun        = r_overrun;
  assign level          = r_level;
  assign underrun_count = r_under_cnt;

endmodule

// File: tb/tb_n64_frame_fifo.sv
module tb_n64_frame_fifo;

  localparam int DEPTH = 64;
  localparam int H     = 4;

  logic        clk = 1'b0;
  logic        rst, wr_en, poll;
  logic [31:0] wr_data;
  logic        request_frame, frame_valid, underrun, overrun;
  logic [31:0] frame_data;
  logic [6:0]  level;
  logic [15:0] underrun_count;

  int total = 0;
  int bad   = 0;

  always #10 clk = ~clk;

  n64_frame_fifo #(.DEPTH(DEPTH), .REQ_HOLDOFF(H), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .request_frame  (request_frame),
    .poll           (poll),
    .frame_data     (frame_data),
    .frame_valid    (frame_valid),
    .underrun       (underrun),
    .overrun        (overrun),
    .level          (level),
    .underrun_count (underrun_count)
  );

  // Behavioural reference: a queue of frames plus the last frame returned.
  logic [31:0] mq[$];
  logic [31:0] m_hold;
  int          m_cnt, m_ho;
  bit          m_req, m_fv, m_ur, m_ov;

  task automatic model_step(input bit r, input bit w, input logic [31:0] d, input bit p);
    bit busy, was_empty, was_full;
    if (r) begin
      mq.delete();
      m_hold = 32'h0; m_cnt = 0; m_ho = 0;
      m_req = 0; m_fv = 0; m_ur = 0; m_ov = 0;
      return;
    end
    busy      = m_fv;
    was_empty = (mq.size() == 0);
    was_full  = (mq.size() == DEPTH);
    m_fv = 0; m_ur = 0; m_ov = 0;
    if (p && !busy) begin
      m_fv = 1;
      if (was_empty) begin
        m_ur = 1;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        m_hold = mq.pop_front();
      end
    end
    if (w && was_full) m_ov = 1;
    if (w && !was_full) begin
      mq.push_back(d);
      m_ho = H;
    end else if (m_ho > 0) begin
      m_ho--;
    end
    m_req = (mq.size() < DEPTH) && (m_ho == 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, clock, step the model, sample #1 after the edge.
  task automatic cyc(input bit r, input bit w, input logic [31:0] d, input bit p);
    rst = r; wr_en = w; wr_data = d; poll = p;
    @(posedge clk);
    model_step(r, w, d, p);
    #1;
    rst = 0; wr_en = 0; poll = 0;
    if (r || w || p)
      $display("t=%0t rst=%0b wr=%0b d=%h poll=%0b -> lvl=%0d req=%0b fv=%0b fd=%h ur=%0b ov=%0b cnt=%0d",
               $time, r, w, d, p, level, request_frame, frame_valid, frame_data,
               underrun, overrun, underrun_count);
    chk("level",          level,          mq.size());
    chk("request_frame",  request_frame,  m_req);
    chk("frame_valid",    frame_valid,    m_fv);
    chk("frame_data",     frame_data,     m_hold);
    chk("underrun",       underrun,       m_ur);
    chk("overrun",        overrun,        m_ov);
    chk("underrun_count", underrun_count, m_cnt);
  endtask

  task automatic do_reset();
    cyc(1, 0, 32'h0, 0);
    chk("rst_req",   request_frame,  0);
    chk("rst_fd",    frame_data,     0);
    chk("rst_fv",    frame_valid,    0);
    chk("rst_ur",    underrun,       0);
    chk("rst_ov",    overrun,        0);
    chk("rst_level", level,          0);
    chk("rst_cnt",   underrun_count, 0);
    cyc(0, 0, 32'h0, 0);
    chk("req_after_rst", request_frame, 1);
  endtask

  typedef struct {
    bit          w;
    logic [31:0] d;
    bit          p;
    bit          fv;
    logic [31:0] fd;
    bit          ur;
    int          lvl;
  } vec_t;

  vec_t tbl[13];

  localparam logic [31:0] FA = 32'h1111_AAAA;
  localparam logic [31:0] FB = 32'h2222_BBBB;
  localparam logic [31:0] FC = 32'h3333_CCCC;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lowcnt;
    bit  saw_beef;
    //              w  d      p  fv fd  ur lvl
    tbl[0]  = '{1, FA,    0, 0, 0,  0, 1};
    tbl[1]  = '{1, FB,    0, 0, 0,  0, 2};
    tbl[2]  = '{1, FC,    0, 0, 0,  0, 3};
    tbl[3]  = '{0, 32'h0, 1, 1, FA, 0, 2};
    tbl[4]  = '{0, 32'h0, 0, 0, FA, 0, 2};
    tbl[5]  = '{0, 32'h0, 1, 1, FB, 0, 1};
    tbl[6]  = '{0, 32'h0, 0, 0, FB, 0, 1};
    tbl[7]  = '{0, 32'h0, 1, 1, FC, 0, 0};
    tbl[8]  = '{0, 32'h0, 0, 0, FC, 0, 0};
    tbl[9]  = '{0, 32'h0, 1, 1, FC, 1, 0};
    tbl[10] = '{0, 32'h0, 0, 0, FC, 0, 0};
    tbl[11] = '{0, 32'h0, 1, 1, FC, 1, 0};
    tbl[12] = '{0, 32'h0, 0, 0, FC, 0, 0};

    rst = 1; wr_en = 0; poll = 0; wr_data = 0;

    // Fill to full, one write every 10 cycles, measuring the holdoff window.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 1, i, 0);
      lowcnt = (request_frame == 0) ? 1 : 0;
      for (int k = 1; k < 10; k++) begin
        cyc(0, 0, 32'h0, 0);
        if (request_frame == 0) lowcnt++;
      end
      chk("holdoff_low_cycles", lowcnt, (i < DEPTH - 1) ? H : 10);
    end
    chk("full_level", level, DEPTH);

    // Write while full: dropped, overrun once, level unchanged.
    cyc(0, 1, 32'hDEAD_BEEF, 0);
    chk("overrun_pulse", overrun, 1);
    chk("overrun_level", level, DEPTH);
    cyc(0, 0, 32'h0, 0);
    chk("overrun_once", overrun, 0);
    chk("req_stays_low", request_frame, 0);
    saw_beef = 0;
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 0, 32'h0, 1);
      chk("drain_data", frame_data, i);
      if (frame_data == 32'hDEAD_BEEF) saw_beef = 1;
      cyc(0, 0, 32'h0, 0);
    end
    chk("no_deadbeef", saw_beef, 0);

    // Three frames, five polls.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      cyc(0, tbl[i].w, tbl[i].d, tbl[i].p);
      chk("tbl_fv",  frame_valid, tbl[i].fv);
      chk("tbl_fd",  frame_data,  tbl[i].fd);
      chk("tbl_ur",  underrun,    tbl[i].ur);
      chk("tbl_lvl", level,       tbl[i].lvl);
    end
    chk("tbl_cnt", underrun_count, 2);

    // Write and poll together into an empty buffer.
    do_reset();
    cyc(0, 1, 32'hCAFE_0001, 1);
    chk("wp0_ur", underrun,   1);
    chk("wp0_fd", frame_data, 0);
    cyc(0, 0, 32'h0, 0);
    chk("wp0_lvl", level, 1);
    cyc(0, 0, 32'h0, 1);
    chk("wp0_next", frame_data, 32'hCAFE_0001);
    cyc(0, 0, 32'h0, 0);

    // Write and poll together at level 5.
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 32'hCAFE_0010 + i, 0);
      for (int k = 0; k < 5; k++) cyc(0, 0, 32'h0, 0);
    end
    cyc(0, 1, 32'hCAFE_0099, 1);
    chk("wp5_lvl", level, 5);
    chk("wp5_fd",  frame_data, 32'hCAFE_0010);
    lowcnt = (request_frame == 0) ? 1 : 0;
    for (int k = 1; k < 10; k++) begin
      cyc(0, 0, 32'h0, 0);
      if (request_frame == 0) lowcnt++;
    end
    chk("wp5_holdoff", lowcnt, H);

    // Reset in the cycle after a poll, with level 10.
    do_reset();
    for (int i = 0; i < 10; i++) cyc(0, 1, 32'hBEE0_0000 + i, 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 32'h0, 0);
    chk("pre_rst_lvl", level, 10);
    rst = 0; wr_en = 0; poll = 1;
    @(posedge clk);
    model_step(0, 0, 32'h0, 1);
    poll = 0;
    rst  = 1;
    #1;
    chk("rst_kills_fv", frame_valid, 0);
    chk("rst_kills_ur", underrun,    0);
    do_reset();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      bit r, w, p;
      r = ($urandom_range(0, 999) < 3);
      if (n < 1500) begin
        w = ($urandom_range(0, 99) < 70);
        p = ($urandom_range(0, 99) < 25);
      end else begin
        w = ($urandom_range(0, 99) < 20);
        p = ($urandom_range(0, 99) < 45);
      end
      cyc(r, w, $urandom, p);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/n64_frame_fifo.md
# n64_frame_fifo

Per-console input-frame buffer between the serial command handler and the N64 controller protocol engine. It stores 32-bit controller frames written by the serial handler and raises `request_frame` while it can accept another frame. It returns one frame per console poll and substitutes a held frame when a poll finds the buffer empty. One instance per console; the `request_frame` outputs of all instances form the serial handler's `request_frame` vector.

## Interface
- `DEPTH`, 64: frame capacity; power of two, ≥4.
- `REQ_HOLDOFF`, 4: cycles `request_frame` is forced low after each accepted write; 0 disables.
- `CNT_W`, 16: width of the underrun counter.

- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: synchronous, active-high; the top level drives it from power-on reset OR `n64_controller_reset`.
- `wr_en` in 1: one-cycle write strobe, connected to `queue_WrEn`.
- `wr_data` in 32: frame to store, connected to `received_frame_data`.
- `request_frame` out 1: high when one more write will be accepted.
- `poll` in 1: one-cycle pulse from the protocol engine requesting the next frame.
- `frame_data` out 32: frame returned for the most recent poll.
- `frame_valid` out 1: one-cycle pulse qualifying `frame_data`.
- `underrun` out 1: one-cycle pulse; the poll found the buffer empty.
- `overrun` out 1: one-cycle pulse; a write arrived while full and was dropped.
- `level` out $clog2(DEPTH)+1: frames currently stored.
- `underrun_count` out CNT_W: saturating count of underruns since reset.

## Operation
- Storage is a circular buffer with `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits and wrapping modulo DEPTH, plus `level`, which ranges 0..DEPTH.
- **Write.** When `wr_en` is high and `level < DEPTH`, the block stores `wr_data` at `wr_ptr`, increments `wr_ptr`, and loads the holdoff counter with REQ_HOLDOFF.
- **Write while full.** When `wr_en` is high and `level == DEPTH`, the data is dropped, pointers and `level` do not change, `overrun` pulses, and the holdoff counter is not reloaded.
- **`request_frame`** is registered and equals (`level_next < DEPTH`) AND (holdoff counter == 0). The holdoff counter decrements to 0 and stops there.
- **Poll, not empty.** When `poll` is high and `level > 0`, the block reads the frame at `rd_ptr`, increments `rd_ptr`, and captures the frame into the hold register.
- **Poll, empty.** When `poll` is high and `level == 0`, the block returns the hold register, leaves pointers unchanged, pulses `underrun`, and increments `underrun_count` unless it is saturated.
- **Simultaneous write and poll.** Both take effect. `level` is unchanged when both succeed. The empty/full tests use `level` at the start of the cycle, so there is no write-to-read bypass: a write into an empty buffer coinciding with a poll produces an underrun.
- **Reset mid-operation.** `rst` discards any pending read result. No `frame_valid` is emitted for a poll sampled in the reset cycle.
- **State machine for the read port:**
  - RD_IDLE: waits for `poll`.
  - RD_FETCH: RAM output registered.
  - RD_IDLE is re-entered with `frame_valid` asserted.
  - `poll` arriving in RD_FETCH is ignored; the protocol engine guarantees at most one poll per 2 cycles.

## Timing
- **Reset values:**
  - `request_frame` = 0
  - `frame_data` = 0 (neutral controller)
  - hold register = 0
  - `frame_valid`, `underrun`, `overrun` = 0
  - `level` = 0
  - `underrun_count` = 0
  - pointers = 0
  - holdoff = 0
- `request_frame` first rises on the 1st cycle after `rst` deasserts.
- A write in cycle t updates `level` at t+1. With REQ_HOLDOFF=H, `request_frame` is low for cycles t+1 through t+H, then re-evaluates.
- A write that makes `level == DEPTH` holds `request_frame` low until a poll frees a slot. `request_frame` re-rises the cycle after that poll when the holdoff has expired.
- Poll latency: a poll in cycle t produces `frame_data` and a `frame_valid` pulse in cycle t+1. `frame_data` holds its value until the next `frame_valid`.
- For a poll in cycle t: `underrun` pulses in t+1, coincident with `frame_valid`, and `level` decrements at t+1.
- `overrun` for a write in cycle t pulses in t+1.

## Structure
- Shared package `n64_tas_pkg`:
  - `FRAME_W` = 32
  - `NEUTRAL_FRAME` = 32'h0
  - the frame typedef
- Sub-module `sync_ram_1r1w`: simple dual-port RAM with `DEPTH` × `FRAME_W`, registered read, and no read-during-write bypass, so that it infers block RAM.
- Pointer, level, holdoff, and read FSM logic live in `n64_frame_fifo`.

## Test plan
- Reset, then 64 writes of 32'h0000_0000 through 32'h0000_003F, one every 10 cycles. Required: `level` = 64; `request_frame` drops to 0 permanently after the 64th write; each write drops `request_frame` for exactly 4 cycles.
- A 65th write of 32'hDEAD_BEEF while full. Required: `overrun` pulses once; `level` stays 64; subsequent polls never return DEAD_BEEF.
- Fill 3 frames (A, B, C), then 5 polls. Required: `frame_valid` follows each poll by 1 cycle with A, B, C, C, C; `underrun` pulses on the 4th and 5th polls; `underrun_count` = 2.
- Write and poll in the same cycle with `level == 0`. Required: `underrun`; `frame_data` = 0; `level` becomes 1. The next poll returns the written frame.
- Write and poll in the same cycle with `level == 5`. Required: `level` stays 5; the frame returned is the oldest; `request_frame` is low for 4 cycles.
- With `level == 10`, assert `rst` in the cycle after a poll. Required: no `frame_valid`; all outputs take their reset values; `request_frame` = 1 one cycle after `rst` deasserts.
